// File: rtl/tt_umn_tinyspu.sv
// Tiny scalar processing unit: one 8-bit instruction per clock against an
// accumulator and an 8-entry register file. Optional MUL under TINYSPU_MUL_EN.
module tt_umn_tinyspu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_LDI  = 4'd1,
        OP_LD   = 4'd2,
        OP_ST   = 4'd3,
        OP_ADD  = 4'd4,
        OP_SUB  = 4'd5,
        OP_AND  = 4'd6,
        OP_OR   = 4'd7,
        OP_XOR  = 4'd8,
        OP_ADDI = 4'd9,
        OP_SHL  = 4'd10,
        OP_SHR  = 4'd11,
        OP_MUL  = 4'd12,
        OP_MAX  = 4'd13,
        OP_FLG  = 4'd14,
        OP_CLR  = 4'd15
    } opcode_t;

    // VALID is a level qualifier, not a handshake: every rising edge with
    // ena=1 and VALID=1 executes the presented instruction, with no ready.
    logic       valid;
    opcode_t    opcode;
    logic [2:0] idx;
    logic [7:0] imm;

    assign valid  = ui_in[7];
    assign opcode = opcode_t'(ui_in[6:3]);
    assign idx    = ui_in[2:0];
    assign imm    = uio_in;

    logic [7:0] acc;
    logic       z;
    logic       c;
    logic [7:0] regs [8];

    logic [7:0] acc_d;
    logic       z_d;
    logic       c_d;
    logic       reg_we;
    logic       clr_all;
    logic       exec;

    logic [7:0] r;
    logic [8:0] add_r;
    logic [8:0] add_imm;
`ifdef TINYSPU_MUL_EN
    logic [15:0] prod;
`endif

    assign exec    = ena & valid;
    assign r       = regs[idx];
    assign add_r   = {1'b0, acc} + {1'b0, r};
    assign add_imm = {1'b0, acc} + {1'b0, imm};
`ifdef TINYSPU_MUL_EN
    assign prod    = {8'h00, acc} * {8'h00, imm};
`endif

    always_comb begin
        acc_d   = acc;
        z_d     = z;
        c_d     = c;
        reg_we  = 1'b0;
        clr_all = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_LDI: begin
                acc_d = imm;
                z_d   = (imm == 8'h00);
            end
            OP_LD: begin
                acc_d = r;
                z_d   = (r == 8'h00);
            end
            OP_ST: reg_we = 1'b1;
            OP_ADD: begin
                acc_d = add_r[7:0];
                c_d   = add_r[8];
                z_d   = (add_r[7:0] == 8'h00);
            end
            OP_SUB: begin
                acc_d = acc - r;
                c_d   = (acc < r);
                z_d   = (acc == r);
            end
            OP_AND: begin
                acc_d = acc & r;
                c_d   = 1'b0;
                z_d   = ((acc & r) == 8'h00);
            end
            OP_OR: begin
                acc_d = acc | r;
                c_d   = 1'b0;
                z_d   = ((acc | r) == 8'h00);
            end
            OP_XOR: begin
                acc_d = acc ^ r;
                c_d   = 1'b0;
                z_d   = ((acc ^ r) == 8'h00);
            end
            OP_ADDI: begin
                acc_d = add_imm[7:0];
                c_d   = add_imm[8];
                z_d   = (add_imm[7:0] == 8'h00);
            end
            OP_SHL: begin
                acc_d = {acc[6:0], 1'b0};
                c_d   = acc[7];
                z_d   = (acc[6:0] == 7'h00);
            end
            OP_SHR: begin
                acc_d = {1'b0, acc[7:1]};
                c_d   = acc[0];
                z_d   = (acc[7:1] == 7'h00);
            end
`ifdef TINYSPU_MUL_EN
            OP_MUL: begin
                acc_d = prod[7:0];
                c_d   = (prod[15:8] != 8'h00);
                z_d   = (prod[7:0] == 8'h00);
            end
`endif
            OP_MAX: begin
                acc_d = (r > acc) ? r : acc;
                c_d   = (r > acc);
                z_d   = (((r > acc) ? r : acc) == 8'h00);
            end
            // Flags are reported as they stood before this edge and left as is.
            OP_FLG: acc_d = {6'b0, c, z};
            OP_CLR: clr_all = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 8'h00;
            z   <= 1'b0;
            c   <= 1'b0;
        end else if (exec) begin
            if (clr_all) begin
                acc <= 8'h00;
                z   <= 1'b0;
                c   <= 1'b0;
            end else begin
                acc <= acc_d;
                z   <= z_d;
                c   <= c_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
        end else if (exec) begin
            if (clr_all) begin
                for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
            end else if (reg_we) begin
                regs[idx] <= acc;
            end
        end
    end

    assign uo_out  = acc;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_umn_tinyspu.sv
// Directed self-checking bench for tt_umn_tinyspu; expected values are
// hand-computed, with the MUL result selected by TINYSPU_MUL_EN.
module tb_tt_umn_tinyspu;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] NOP = 4'd0, LDI = 4'd1, LD = 4'd2, ST = 4'd3,
                         ADD = 4'd4, SUB = 4'd5, ANDR = 4'd6, ORR = 4'd7,
                         XORR = 4'd8, ADDI = 4'd9, SHL = 4'd10, SHR = 4'd11,
                         MUL = 4'd12, MAX = 4'd13, FLG = 4'd14, CLR = 4'd15;

  tt_umn_tinyspu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking task
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after a rising edge
  task automatic issue_n(input logic [3:0] op, input logic [2:0] idx,
                         input logic [7:0] imm, input int n);
    ui_in  = {1'b1, op, idx};
    uio_in = imm;
    repeat (n) @(posedge clk);
    #1;
    ui_in  = {1'b0, NOP, 3'd0};
    uio_in = $urandom_range(0, 255);
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] idx, input logic [7:0] imm);
    issue_n(op, idx, imm, 1);
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [2:0] idx,
                     input logic [7:0] imm, input logic [7:0] exp);
    issue(op, idx, imm);
    check(tag, uo_out, exp);
  endtask

  initial begin
    ena    = 1'b1;
    rst_n  = 1'b0;
    ui_in  = 8'($urandom_range(0, 255));
    uio_in = 8'($urandom_range(0, 255));
    repeat (2) begin
      @(posedge clk);
      #1;
      ui_in = 8'($urandom_range(0, 255));
    end
    check("reset_acc", uo_out, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'h00);
    ui_in = 8'h00;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("reset_flg", FLG, 3'd0, 8'h00, 8'h00);

    // load / store / load with gated cycles
    run("ldi_5a", LDI, 3'd0, 8'h5A, 8'h5A);
    run("st_r3", ST, 3'd3, 8'h00, 8'h5A);
    run("ldi_00", LDI, 3'd0, 8'h00, 8'h00);
    ui_in = {1'b0, LDI, 3'd0}; uio_in = 8'h77;
    @(posedge clk); #1;
    check("valid_low_hold", uo_out, 8'h00);
    ena = 1'b0; ui_in = {1'b1, LDI, 3'd0};
    @(posedge clk); #1;
    check("ena_low_hold", uo_out, 8'h00);
    ena = 1'b1; ui_in = 8'h00;
    run("ld_r3", LD, 3'd3, 8'h00, 8'h5A);

    // carry wrap
    run("ldi_f0", LDI, 3'd0, 8'hF0, 8'hF0);
    run("st_r1", ST, 3'd1, 8'h00, 8'hF0);
    run("ldi_20", LDI, 3'd0, 8'h20, 8'h20);
    run("add_wrap", ADD, 3'd1, 8'h00, 8'h10);
    run("flg_carry", FLG, 3'd0, 8'h00, 8'h02);

    // borrow / zero
    run("ldi_05", LDI, 3'd0, 8'h05, 8'h05);
    run("st_r2", ST, 3'd2, 8'h00, 8'h05);
    run("sub_zero", SUB, 3'd2, 8'h00, 8'h00);
    run("flg_zero", FLG, 3'd0, 8'h00, 8'h01);
    run("ldi_03", LDI, 3'd0, 8'h03, 8'h03);
    run("sub_borrow", SUB, 3'd2, 8'h00, 8'hFE);
    run("flg_borrow", FLG, 3'd0, 8'h00, 8'h02);

    // shifts
    run("ldi_81a", LDI, 3'd0, 8'h81, 8'h81);
    run("shl", SHL, 3'd0, 8'h00, 8'h02);
    run("flg_shl", FLG, 3'd0, 8'h00, 8'h02);
    run("ldi_81b", LDI, 3'd0, 8'h81, 8'h81);
    run("shl2", SHL, 3'd0, 8'h00, 8'h02);
    run("shr", SHR, 3'd0, 8'h00, 8'h01);
    run("flg_shr", FLG, 3'd0, 8'h00, 8'h00);

    // logic
    run("ldi_f0b", LDI, 3'd0, 8'hF0, 8'hF0);
    run("st_r0", ST, 3'd0, 8'h00, 8'hF0);
    run("ldi_3c", LDI, 3'd0, 8'h3C, 8'h3C);
    run("xor", XORR, 3'd0, 8'h00, 8'hCC);
    run("ldi_3cb", LDI, 3'd0, 8'h3C, 8'h3C);
    run("and", ANDR, 3'd0, 8'h00, 8'h30);
    run("or", ORR, 3'd0, 8'h00, 8'hF0);
    run("flg_logic", FLG, 3'd0, 8'h00, 8'h00);

    // ADDI wrap to zero
    run("ldi_ff", LDI, 3'd0, 8'hFF, 8'hFF);
    run("addi_wrap", ADDI, 3'd0, 8'h01, 8'h00);
    run("flg_addi", FLG, 3'd0, 8'h00, 8'h03);

    // MAX against R3 = 0x5A
    run("ldi_10", LDI, 3'd0, 8'h10, 8'h10);
    run("max_r", MAX, 3'd3, 8'h00, 8'h5A);
    run("flg_max_r", FLG, 3'd0, 8'h00, 8'h02);
    run("ldi_80", LDI, 3'd0, 8'h80, 8'h80);
    run("max_acc", MAX, 3'd3, 8'h00, 8'h80);
    run("flg_max_acc", FLG, 3'd0, 8'h00, 8'h00);

    // level-sensitive repeat: three ADDI executions
    run("ldi_01", LDI, 3'd0, 8'h01, 8'h01);
    issue_n(ADDI, 3'd0, 8'h01, 3);
    check("addi_x3", uo_out, 8'h04);

    // MUL / CLR
    run("ldi_12", LDI, 3'd0, 8'h12, 8'h12);
`ifdef TINYSPU_MUL_EN
    run("mul", MUL, 3'd0, 8'h10, 8'h20);
    run("flg_mul", FLG, 3'd0, 8'h00, 8'h02);
`else
    run("mul_nop", MUL, 3'd0, 8'h10, 8'h12);
    run("flg_mul_nop", FLG, 3'd0, 8'h00, 8'h00);
`endif
    run("ldi_ff2", LDI, 3'd0, 8'hFF, 8'hFF);
    run("addi_c", ADDI, 3'd0, 8'h02, 8'h01);
    run("clr", CLR, 3'd0, 8'h00, 8'h00);
    run("flg_clr", FLG, 3'd0, 8'h00, 8'h00);
    run("ld_r0_clr", LD, 3'd0, 8'h00, 8'h00);
    run("ld_r3_clr", LD, 3'd3, 8'h00, 8'h00);

    // asynchronous reset in mid-cycle
    run("ldi_77", LDI, 3'd0, 8'h77, 8'h77);
    #2 rst_n = 1'b0;
    #1 check("async_reset", uo_out, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run("ldi_after_rst", LDI, 3'd0, 8'h33, 8'h33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tt_umn_tinyspu.md
Name: tt_umn_tinyspu

Overview:
- Tiny Scalar Processing Unit (SPU) for a TinyTapeout user slot.
- Executes one 8-bit instruction per clock, supplied on the dedicated inputs, against an 8-bit accumulator (ACC) and an 8 x 8-bit register file (R0..R7).
- ACC is always visible on uo_out; the uio bus is a data/immediate input only.
- Sits at the top level as the user project, with standard TinyTapeout pins.

Parameters:
- None. Widths are fixed: data 8 bits, 8 registers, 4-bit opcode.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low; clears all state.
- ena  input  1  design enable; when 0, all state holds.
- ui_in  input  8  instruction: [7]=VALID, [6:3]=OPCODE, [2:0]=IDX (register index).
- uo_out  output  8  current ACC value (registered).
- uio_in  input  8  immediate operand IMM.
- uio_out  output  8  constant 8'h00.
- uio_oe  output  8  constant 8'h00; all uio pins are inputs.

Behaviour:
- Reset (rst_n=0, asynchronous): ACC=0, R0..R7=0, Z=0, C=0. uo_out=0 immediately.
- Execution gate:
  - An instruction executes on a rising clk edge only when ena=1 and VALID=1.
  - Otherwise ACC, the register file and the flags hold their values.
  - Execution is level-sensitive: holding VALID=1 for N cycles executes the instruction N times.
- Latency:
  - The result is visible on uo_out in the cycle after the executing edge.
  - A register written at edge k is read with its new value at edge k+1 or later.
- Flags:
  - Z = (new ACC == 0); C = carry/borrow/shift-out.
  - Both are updated only by the opcodes that name them below; all other opcodes preserve them.
- Arithmetic: all results are truncated to 8 bits and unsigned.
- Opcodes (R = R[IDX]):
  - 0 NOP: no change.
  - 1 LDI: ACC<=IMM; Z updated.
  - 2 LD: ACC<=R; Z updated.
  - 3 ST: R<=ACC; flags unchanged.
  - 4 ADD: {C,ACC}<=ACC+R; Z updated.
  - 5 SUB: ACC<=ACC-R; C=1 if ACC<R (borrow); Z updated.
  - 6 AND: ACC<=ACC&R; Z updated, C=0.
  - 7 OR: ACC<=ACC|R; Z updated, C=0.
  - 8 XOR: ACC<=ACC^R; Z updated, C=0.
  - 9 ADDI: {C,ACC}<=ACC+IMM; Z updated.
  - 10 SHL: C<=ACC[7]; ACC<=ACC<<1; Z updated.
  - 11 SHR: C<=ACC[0]; ACC<=ACC>>1 (logical); Z updated.
  - 12 MUL: see Optional Feature.
  - 13 MAX: ACC<=max(ACC,R) unsigned; Z updated, C=1 if R>ACC.
  - 14 FLG: ACC<={6'b0,C,Z}, using flag values before the edge; flags unchanged.
  - 15 CLR: ACC, R0..R7, Z and C all cleared to 0.
- Operand aliasing: ST to R[IDX] while the same opcode reads R[IDX] cannot occur; one opcode per cycle.
- Wrap-around: ADD/ADDI overflow wraps modulo 256 with C=1. SUB underflow wraps modulo 256 with C=1.
- Reset mid-operation: an asynchronous reset overrides any in-flight instruction; the first instruction after rst_n rises executes at the next qualifying edge.
- Unused inputs: IMM is ignored by opcodes that do not use it. IDX is ignored by opcodes that do not use R.

Optional Feature:
- Macro: TINYSPU_MUL_EN.
- Defined: opcode 12 MUL is implemented.
  - {hi,ACC}<=ACC*IMM (16-bit product).
  - ACC takes the low byte.
  - C=1 if the high byte is nonzero.
  - Z updated from the new ACC.
  - Single cycle.
- Not defined: opcode 12 behaves exactly as NOP (no state or flag change) and no multiplier is synthesised.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random ui_in -> uo_out=8'h00, uio_out=8'h00, uio_oe=8'h00; FLG afterwards -> uo_out=8'h00.
- Load/store/load: LDI IMM=0x5A, ST IDX=3, LDI IMM=0x00, LD IDX=3 -> uo_out=0x5A; an intervening VALID=0 or ena=0 cycle leaves uo_out unchanged.
- Carry wrap: LDI 0xF0, ST R1, LDI 0x20, ADD R1 -> uo_out=0x10; FLG -> uo_out=0x02 (C=1, Z=0).
- Borrow/zero:
  - LDI 0x05, ST R2, SUB R2 -> uo_out=0x00; FLG -> 0x01.
  - LDI 0x03, SUB R2 -> 0xFE; FLG -> 0x02.
- Shifts/logic:
  - LDI 0x81, SHL -> 0x02 with C=1; SHR -> 0x01 with C=0.
  - LDI 0xF0, ST R0, LDI 0x3C, XOR R0 -> 0xCC.
- MUL/CLR:
  - LDI 0x12, MUL IMM=0x10 -> 0x20 with C=1 when TINYSPU_MUL_EN is defined; uo_out stays 0x12 when it is not.
  - CLR, then LD R0 -> 0x00.
